// File: rtl/sev_seg_capture.sv
// ---------------------------------------------------------------------------
// sev_seg_capture
//
// Purpose:
//   Watches a multiplexed seven-segment display bus and recovers the hex value
//   shown on each digit. The bus {seg, dp, an} is registered every cycle. Once
//   the same sample has been seen STABLE_CYCLES times in a row, it is acted on
//   exactly once. It is not acted on again until the sample changes.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   seg[6:0]     in   segment lines {a,b,c,d,e,f,g}, active-high, a = MSB
//   dp           in   decimal-point line, active-high
//   an[N-1:0]    in   digit enables, active-high, legal value is one-hot
//   digits       out  captured values, digit i at [4i+3:4i]
//   digit_valid  out  digit i holds a legally decoded value
//   dp_bits      out  last captured dp per digit
//   upd_valid    out  one-cycle pulse: a digit value was captured
//   upd_idx      out  index of captured digit (held between pulses)
//   upd_value    out  captured value (held between pulses)
//   bad_pattern  out  one-cycle pulse: stable, non-blank, non-hex pattern
//   bad_enable   out  one-cycle pulse: stable enable with several bits set
//
// Handshake: upd_valid is a single-cycle strobe with no ready/back-pressure.
// upd_idx and upd_value are meaningful only in the cycle upd_valid is high.
// ---------------------------------------------------------------------------
module sev_seg_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic                    dp,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   dp_bits,
   output logic                    upd_valid,
   output logic [2:0]              upd_idx,
   output logic [3:0]              upd_value,
   output logic                    bad_pattern,
   output logic                    bad_enable
);

   localparam int SW = 8 + NUM_DIGITS;

   // Sample register layout: {seg[6:0], dp, an[N-1:0]}
   logic [SW-1:0]           sample_q, sample_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    captured_q, captured_d;

   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
   logic [NUM_DIGITS-1:0]   dp_bits_q, dp_bits_d;
   logic                    upd_valid_q, upd_valid_d;
   logic [2:0]              upd_idx_q, upd_idx_d;
   logic [3:0]              upd_value_q, upd_value_d;
   logic                    bad_pattern_q, bad_pattern_d;
   logic                    bad_enable_q, bad_enable_d;

   logic                    same;
   logic                    fire;
   logic [6:0]              s_seg;
   logic                    s_dp;
   logic [NUM_DIGITS-1:0]   s_an;
   logic [4:0]              dec;

   // Inverse of the hex-to-segment table: {legal, value}
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1111110: r = {1'b1, 4'h0};
         7'b0110000: r = {1'b1, 4'h1};
         7'b1101101: r = {1'b1, 4'h2};
         7'b1111001: r = {1'b1, 4'h3};
         7'b0110011: r = {1'b1, 4'h4};
         7'b1011011: r = {1'b1, 4'h5};
         7'b1011111: r = {1'b1, 4'h6};
         7'b1110000: r = {1'b1, 4'h7};
         7'b1111111: r = {1'b1, 4'h8};
         7'b1111011: r = {1'b1, 4'h9};
         7'b1110111: r = {1'b1, 4'hA};
         7'b0011111: r = {1'b1, 4'hB};
         7'b1001110: r = {1'b1, 4'hC};
         7'b0111101: r = {1'b1, 4'hD};
         7'b1001111: r = {1'b1, 4'hE};
         7'b1000111: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   assign s_seg = sample_q[SW-1 -: 7];
   assign s_dp  = sample_q[NUM_DIGITS];
   assign s_an  = sample_q[NUM_DIGITS-1:0];

   always_comb begin
      sample_d      = {seg, dp, an};
      same          = (sample_d == sample_q);
      dec           = decode(s_seg);

      // Saturating stability counter; any change restarts the dwell at 1.
      if (!same)                cnt_d = 8'd1;
      else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
      else                      cnt_d = cnt_q;

      // The captured flag keeps a long-held (or saturated) sample from
      // acting twice; it clears whenever the sample changes.
      fire          = (cnt_q == 8'(STABLE_CYCLES)) && !captured_q;
      captured_d    = same ? (captured_q | fire) : 1'b0;

      digits_d      = digits_q;
      digit_valid_d = digit_valid_q;
      dp_bits_d     = dp_bits_q;
      upd_idx_d     = upd_idx_q;
      upd_value_d   = upd_value_q;
      upd_valid_d   = 1'b0;
      bad_pattern_d = 1'b0;
      bad_enable_d  = 1'b0;

      if (fire) begin
         if ((s_an != '0) && !$onehot(s_an)) begin
            bad_enable_d = 1'b1;
         end else begin
            // an is zero or one-hot here, so at most one iteration matches.
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (s_an[i]) begin
                  dp_bits_d[i] = s_dp;
                  if (s_seg == 7'b0000000) begin
                     digit_valid_d[i] = 1'b0;
                  end else if (dec[4]) begin
                     digits_d[4*i +: 4] = dec[3:0];
                     digit_valid_d[i]   = 1'b1;
                     upd_valid_d        = 1'b1;
                     upd_idx_d          = 3'(i);
                     upd_value_d        = dec[3:0];
                  end else begin
                     digit_valid_d[i] = 1'b0;
                     bad_pattern_d    = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q      <= '0;
         cnt_q         <= '0;
         captured_q    <= 1'b0;
         digits_q      <= '0;
         digit_valid_q <= '0;
         dp_bits_q     <= '0;
         upd_valid_q   <= 1'b0;
         upd_idx_q     <= '0;
         upd_value_q   <= '0;
         bad_pattern_q <= 1'b0;
         bad_enable_q  <= 1'b0;
      end else begin
         sample_q      <= sample_d;
         cnt_q         <= cnt_d;
         captured_q    <= captured_d;
         digits_q      <= digits_d;
         digit_valid_q <= digit_valid_d;
         dp_bits_q     <= dp_bits_d;
         upd_valid_q   <= upd_valid_d;
         upd_idx_q     <= upd_idx_d;
         upd_value_q   <= upd_value_d;
         bad_pattern_q <= bad_pattern_d;
         bad_enable_q  <= bad_enable_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = digit_valid_q;
   assign dp_bits     = dp_bits_q;
   assign upd_valid   = upd_valid_q;
   assign upd_idx     = upd_idx_q;
   assign upd_value   = upd_value_q;
   assign bad_pattern = bad_pattern_q;
   assign bad_enable  = bad_enable_q;

endmodule

// File: doc/sev_seg_capture.md
Name: sev_seg_capture

Overview:
- Receive-side counterpart of the team's hex-to-seven-segment decoder. Monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit enables) and recovers the hex value shown on each digit.
- Used as a bench/loopback checker and as a readback path for display drivers, converting segment patterns back to 4-bit values.
- Sits between a display-scan driver's output pins and any logic or host needing the displayed values.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high, a = MSB.
- dp  input  1  decimal-point line, active-high.
- an  input  NUM_DIGITS  digit enables, active-high; a legal enable is one-hot; bit i selects digit i.
- digits  output  4*NUM_DIGITS  captured values; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a legally decoded value.
- dp_bits  output  NUM_DIGITS  last captured dp per digit.
- upd_valid  output  1  one-cycle pulse: a digit was captured.
- upd_idx  output  3  index of the captured digit; valid with upd_valid.
- upd_value  output  4  value captured; valid with upd_valid.
- bad_pattern  output  1  one-cycle pulse: a stable, non-blank, non-hex pattern was seen.
- bad_enable  output  1  one-cycle pulse: an had more than one bit set for STABLE_CYCLES consecutive samples.

Behaviour:
- Reset (synchronous, highest priority): all outputs, sample registers, the stability counter and the captured flag clear to 0. Reset mid-dwell discards the partial dwell. Counting restarts on the first edge after rst deasserts.
- Sampling: {seg,dp,an} is registered every edge. A sample identical to the previous one increments a saturating stability counter. Any difference reloads the counter to 1 and clears the captured flag.
- Capture condition: counter reaches STABLE_CYCLES while captured flag = 0. Act once, then set captured flag; no further action until the sample changes.
- Capture actions, by sampled an:
  - an = 0: no action, no pulse.
  - an not one-hot: pulse bad_enable; no digit state changes.
  - an one-hot, index i:
    - seg = 7'b0000000 (blank): digit_valid[i] <= 0; digits[i] unchanged; dp_bits[i] <= dp; no pulse.
    - Legal hex pattern: digits[i] <= value; digit_valid[i] <= 1; dp_bits[i] <= dp; upd_valid = 1, upd_idx = i, upd_value = value.
    - Any other pattern: digit_valid[i] <= 0; dp_bits[i] <= dp; pulse bad_pattern.
- Legal patterns (exact inverse table, 7-bit match):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Latency:
  - A new pattern first sampled at edge k is captured at edge k+STABLE_CYCLES-1.
  - Pulses and updated digits/digit_valid/dp_bits are visible after edge k+STABLE_CYCLES.
- Pulse timing: upd_valid, bad_pattern and bad_enable are each high for exactly one cycle and are mutually exclusive. upd_idx and upd_value hold their last values while upd_valid = 0.
- Dwell rules:
  - A pattern held indefinitely produces exactly one capture.
  - A glitch shorter than STABLE_CYCLES samples produces no capture and restarts the dwell of the following pattern.
  - The same digit value re-presented after any intervening change is captured again.
- Counter: 8-bit, saturates at 255; saturation never re-triggers a capture.

Test Plan:
- Reset/basic capture: rst high 3 cycles, then all outputs 0. Apply an=0001, seg=1101101, held 10 cycles -> upd_valid is one pulse 4 edges after first sample, upd_idx=0, upd_value=2; digits[3:0]=2, digit_valid=0001; no second pulse.
- Full scan: cycle digits 0..3 with values A, b, C, d (patterns 1110111, 0011111, 1001110, 0111101), 6 cycles each -> digits=16'hDCBA, digit_valid=1111, four upd_valid pulses, idx 0,1,2,3 in order.
- Glitch rejection: digit 1 shows 8 for 3 cycles then 1 for 5 cycles -> no capture of 8; one capture of value 1 at idx 1.
- Illegal/blank: digit 2 after value 5 captured, apply seg=1000000 stable -> bad_pattern pulse, digit_valid[2]=0. Then seg=0000000 -> no pulse, digit_valid[2] stays 0.
- Enable faults: an=0011 stable 6 cycles -> single bad_enable pulse, digits unchanged. an=0000 -> no pulses.
- Reset mid-operation: rst asserted at the 2nd cycle of a dwell on digit 3 with value F and dp=1 -> all outputs 0 after reset. Dwell restarts after release; capture occurs 4 edges later with dp_bits[3]=1.
